// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with a prefetch queue and a single outstanding memory request.
// Define IF_ALIGN_CHECK_EN to flag misaligned redirects and halt fetch instead of masking the low PC bits.
module if_stage #(
  parameter int DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opCode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        fetch_excp
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH, HALT} state_t;
  state_t state;
  logic [31:0] pc, req_addr, new_pc, pc_eff;
  logic [31:0] q_pc [DEPTH];
  logic [31:0] q_word [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, count_next;
  logic flush, push, pop, room, excp, excp_next;
`ifdef IF_ALIGN_CHECK_EN
  assign new_pc = redirect_pc;
  assign excp_next = excp | (flush & |redirect_pc[1:0]);
`else
  assign new_pc = redirect_pc & ~32'd3;
  assign excp_next = 1'b0;
`endif
  assign flush = redirect && state != HALT;
  assign push = state == BUSY && imem_ack && !flush;
  assign pop = inst_valid && !stall && !redirect;
  assign count_next = flush ? '0 : count + CW'(push) - CW'(pop);
  assign room = count_next < CW'(DEPTH);
  assign pc_eff = flush ? new_pc : pc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_addr <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
      excp <= 1'b0;
    end else begin
      count <= count_next;
      excp <= excp_next;
      head <= flush ? '0 : head + AW'(pop);
      tail <= flush ? '0 : tail + AW'(push);
      pc <= push ? pc + 32'd4 : pc_eff;
      case (state)
        IDLE: begin
          if (excp_next) state <= HALT;
          else if (room) begin
            req_addr <= pc_eff;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (flush) state <= imem_ack ? (excp_next ? HALT : IDLE) : FLUSH;
          else if (imem_ack) begin
            if (room) req_addr <= pc + 32'd4;
            else state <= IDLE;
          end
        end
        FLUSH: if (imem_ack) state <= excp_next ? HALT : IDLE;
        default: ;
      endcase
    end
  end
  // queue storage needs no reset: entries are only visible while counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail] <= req_addr;
      q_word[tail] <= imem_rdata;
    end
  end
  assign imem_req = state == BUSY || state == FLUSH;
  assign imem_addr = imem_req ? req_addr : '0;
  assign inst_valid = count != '0;
  assign inst = inst_valid ? q_word[head] : '0;
  assign inst_pc = inst_valid ? q_pc[head] : '0;
  assign opCode = inst[31:26];
  assign funct = inst[5:0];
  assign rs = inst[25:21];
  assign rt = inst[20:16];
  assign rd = inst[15:11];
  assign shamt = inst[10:6];
  assign imm = inst[15:0];
  assign fetch_excp = excp;
endmodule
